// File: rtl/pipe_stage_hs.sv
// Generic pipeline stage register with valid/ready handshake, synchronous
// flush and an optional 2-entry skid buffer that registers in_ready.
module pipe_stage_hs #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SKID  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]       occ_q;
  logic [1:0]       occ_d;
  logic             valid_q;
  logic             ready_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
  logic             in_fire_c;
  logic             out_fire_c;

  // Without skid, ready passes straight through; with skid it comes from a flop.
  assign in_ready   = (SKID != 0) ? ready_q : (~valid_q | out_ready);
  assign in_fire_c  = in_valid & in_ready;
  assign out_fire_c = valid_q & out_ready;

  assign out_valid  = valid_q;
  assign out_data   = main_q;
  assign occupancy  = occ_q;

  // State and payload registers; ready/valid are decoded from next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q   <= ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      occ_q   <= occ_d;
      valid_q <= (occ_d != ST_EMPTY);
      ready_q <= (occ_d != ST_TWO);
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state: clear wins over handshake; skid mode adds the TWO state.
  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    if (clear) begin
      occ_d  = ST_EMPTY;
      main_d = '0;
      skid_d = '0;
    end else if (SKID == 0) begin
      if (in_fire_c) begin
        occ_d  = ST_ONE;
        main_d = in_data;
      end else if (out_fire_c) begin
        occ_d = ST_EMPTY;
      end
    end else begin
      case (occ_q)
        ST_EMPTY: begin
          if (in_fire_c) begin
            occ_d  = ST_ONE;
            main_d = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire_c && out_fire_c) begin
            main_d = in_data;
          end else if (in_fire_c) begin
            occ_d  = ST_TWO;
            skid_d = in_data;
          end else if (out_fire_c) begin
            occ_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire_c) begin
            occ_d  = ST_ONE;
            main_d = skid_q;
          end
        end
        default: begin
          occ_d = ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: index 0 is the SKID=0 instance, index 1 SKID=1.
module tb_pipe_stage_hs;

  logic        clk;
  logic        reset;
  logic        clear     [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] in_data   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_data  [2];
  logic [1:0]  occupancy [2];

  int n_chk = 0;
  int n_err = 0;

  pipe_stage_hs #(.WIDTH(32), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .clear(clear[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .occupancy(occupancy[0])
  );

  pipe_stage_hs #(.WIDTH(32), .SKID(1)) dut1 (
    .clk(clk), .reset(reset), .clear(clear[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .occupancy(occupancy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-instance scoreboard: push on in fire, pop and compare on out fire.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic [31:0] q[$];
    logic [31:0] exp_d;
    logic [31:0] stall_d;
    bit          stall_q = 1'b0;
    int          n44 = 0;

    always @(negedge clk) begin
      if (!reset) begin
        q.delete();
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          chk("stall_valid", 32'(out_valid[g]), 32'd1);
          chk("stall_data", out_data[g], stall_d);
        end
        stall_q = out_valid[g] & ~out_ready[g] & ~clear[g];
        stall_d = out_data[g];
        if (out_valid[g] && out_ready[g]) begin
          if (out_data[g] == 32'h44) n44++;
          if (q.size() == 0) begin
            chk("sb_underflow", 32'(q.size()), 32'd1);
          end else begin
            exp_d = q.pop_front();
            chk("sb_data", out_data[g], exp_d);
          end
        end
        if (clear[g]) q.delete();
        else if (in_valid[g] && in_ready[g]) q.push_back(in_data[g]);
      end
    end
  end

  task automatic stream(input int m);
    out_ready[m] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid[m] = 1'b1;
      in_data[m]  = 32'(i);
      @(negedge clk);
      chk("stream_rdy", 32'(in_ready[m]), 32'd1);
      if (i > 1) begin
        chk("stream_valid", 32'(out_valid[m]), 32'd1);
        chk("stream_data", out_data[m], 32'(i - 1));
      end
      step();
    end
    in_valid[m] = 1'b0;
    @(negedge clk);
    chk("stream_last", out_data[m], 32'd8);
    step();
    step();
    @(negedge clk);
    chk("stream_drained", 32'(occupancy[m]), 32'd0);
    step();
  endtask

  task automatic clear_out_fire(input int m);
    out_ready[m] = 1'b0;
    in_valid[m]  = 1'b1;
    in_data[m]   = 32'h44;
    step();
    in_valid[m]  = 1'b0;
    out_ready[m] = 1'b1;
    clear[m]     = 1'b1;
    step();
    clear[m] = 1'b0;
    @(negedge clk);
    chk("clrfire_occ", 32'(occupancy[m]), 32'd0);
    chk("clrfire_valid", 32'(out_valid[m]), 32'd0);
    step();
  endtask

  initial begin
    reset = 1'b0;
    for (int m = 0; m < 2; m++) begin
      clear[m]     = 1'b0;
      in_valid[m]  = 1'b1;
      in_data[m]   = 32'hDEADBEEF;
      out_ready[m] = 1'b1;
    end

    // Reset held with a valid upstream payload.
    step();
    step();
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("rst_valid", 32'(out_valid[m]), 32'd0);
      chk("rst_data", out_data[m], 32'd0);
      chk("rst_occ", 32'(occupancy[m]), 32'd0);
      chk("rst_rdy", 32'(in_ready[m]), 32'd1);
    end
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("first_valid", 32'(out_valid[m]), 32'd1);
      chk("first_data", out_data[m], 32'hDEADBEEF);
      in_valid[m] = 1'b0;
    end
    step();
    step();

    stream(0);
    stream(1);

    // SKID=1 back-pressure and recovery.
    out_ready[1] = 1'b1;
    in_valid[1]  = 1'b1;
    in_data[1]   = 32'hA;
    step();
    in_data[1]   = 32'hB;
    out_ready[1] = 1'b0;
    @(negedge clk);
    chk("bp1_rdy_b", 32'(in_ready[1]), 32'd1);
    step();
    in_data[1] = 32'hC;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("bp1_occ", 32'(occupancy[1]), 32'd2);
      chk("bp1_rdy", 32'(in_ready[1]), 32'd0);
      chk("bp1_data", out_data[1], 32'hA);
      step();
    end
    out_ready[1] = 1'b1;
    @(negedge clk);
    chk("bp1_rdy_rel", 32'(in_ready[1]), 32'd0);
    step();
    @(negedge clk);
    chk("bp1_recover_rdy", 32'(in_ready[1]), 32'd1);
    chk("bp1_data_b", out_data[1], 32'hB);
    step();
    in_valid[1] = 1'b0;
    @(negedge clk);
    chk("bp1_data_c", out_data[1], 32'hC);
    step();
    step();
    @(negedge clk);
    chk("bp1_drained", 32'(occupancy[1]), 32'd0);

    // SKID=0 back-pressure: ready follows out_ready in the same cycle.
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_data[0]   = 32'h55;
    step();
    out_ready[0] = 1'b0;
    in_data[0]   = 32'h66;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp0_rdy", 32'(in_ready[0]), 32'd0);
      chk("bp0_data", out_data[0], 32'h55);
      step();
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp0_rdy_rel", 32'(in_ready[0]), 32'd1);
    step();
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("bp0_data_66", out_data[0], 32'h66);
    step();
    step();

    // SKID=1 flush from TWO with a pending upstream payload.
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b1;
    in_data[1]   = 32'h11;
    step();
    in_data[1] = 32'h22;
    step();
    @(negedge clk);
    chk("flush1_full", 32'(occupancy[1]), 32'd2);
    in_data[1] = 32'h33;
    clear[1]   = 1'b1;
    step();
    clear[1]    = 1'b0;
    in_valid[1] = 1'b0;
    @(negedge clk);
    chk("flush1_occ", 32'(occupancy[1]), 32'd0);
    chk("flush1_valid", 32'(out_valid[1]), 32'd0);
    chk("flush1_data", out_data[1], 32'd0);
    chk("flush1_rdy", 32'(in_ready[1]), 32'd1);
    out_ready[1] = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("flush1_idle", 32'(out_valid[1]), 32'd0);

    // SKID=0 flush that coincides with an in fire: payload is dropped.
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_data[0]   = 32'h33;
    clear[0]     = 1'b1;
    step();
    clear[0]    = 1'b0;
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("flush0_valid", 32'(out_valid[0]), 32'd0);
    chk("flush0_data", out_data[0], 32'd0);
    step();

    clear_out_fire(0);
    clear_out_fire(1);
    chk("clrfire_cnt0", 32'(g_mon[0].n44), 32'd1);
    chk("clrfire_cnt1", 32'(g_mon[1].n44), 32'd1);
    chk("sb_drain0", 32'(g_mon[0].q.size()), 32'd0);
    chk("sb_drain1", 32'(g_mon[1].q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
